// File: rtl/gth_link_sequencer.sv
// GTH TX link bring-up sequencer: resets and waits for the GT, MMCM and wizard,
// supervises the running link and retries failed attempts up to a sticky FAULT.
module gth_link_sequencer #(
   parameter int unsigned RST_HOLD  = 16,
   parameter int unsigned TIMEOUT   = 1250000,
   parameter int unsigned MAX_RETRY = 7
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       link_en,
   input  logic       fault_clr,
   input  logic [2:0] gtpowergood,
   input  logic [2:0] txpmaresetdone,
   input  logic [2:0] txprgdivresetdone,
   input  logic       tx_done,
   input  logic       locked,
   input  logic       underflow,
   output logic       gt_reset,
   output logic       pixel_en,
   output logic       link_up,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);

   localparam int unsigned TMR_MAX = ((TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD) - 1;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1) + 1;
   localparam int unsigned SYNC_W  = 12;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RST       = 3'd1,
      S_WAIT_PWR  = 3'd2,
      S_WAIT_LOCK = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_RUN       = 3'd5,
      S_FAULT     = 3'd6
   } state_e;

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   logic [SYNC_W-1:0] meta_q, sync_q;
   logic [2:0]        pg_s, pma_s, prg_s;
   logic              txd_s, lock_s, uf_s;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [3:0]        retry_q, retry_d, retry_inc;
   logic              fail, timed_out;
   logic              gt_reset_q, pixel_en_q, link_up_q, fault_q;

   // Reset asserts asynchronously, releases two clocks after resetn rises
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync_q <= '0;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {gtpowergood, txpmaresetdone, txprgdivresetdone, tx_done, locked, underflow};
         sync_q <= meta_q;
      end
   end
   assign {pg_s, pma_s, prg_s, txd_s, lock_s, uf_s} = sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         retry_q    <= '0;
         gt_reset_q <= 1'b1;
         pixel_en_q <= 1'b0;
         link_up_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         gt_reset_q <= (state_d inside {S_IDLE, S_RST, S_FAULT});
         pixel_en_q <= (state_d == S_RUN);
         link_up_q  <= (state_d == S_RUN);
         fault_q    <= (state_d == S_FAULT);
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      fail      = 1'b0;
      retry_inc = retry_q;
      timer_d   = timer_q;
      timed_out = (timer_q >= TMR_W'(TIMEOUT - 1));

      // Exit conditions are tested before the timeout so they win a tie
      unique case (state_q)
         S_IDLE:      if (link_en) state_d = S_RST;
         S_RST:       if (timer_q >= TMR_W'(RST_HOLD - 1)) state_d = S_WAIT_PWR;
         S_WAIT_PWR:  if (&pg_s) state_d = S_WAIT_LOCK;
                      else if (timed_out) fail = 1'b1;
         S_WAIT_LOCK: if (lock_s) state_d = S_WAIT_DONE;
                      else if (timed_out) fail = 1'b1;
         S_WAIT_DONE: if (txd_s && (&pma_s) && (&prg_s)) state_d = S_RUN;
                      else if (timed_out) fail = 1'b1;
         S_RUN:       if (uf_s || !lock_s || !txd_s) fail = 1'b1;
                      else if (timed_out) retry_d = '0;
         S_FAULT:     if (fault_clr) begin
                         state_d = S_IDLE;
                         retry_d = '0;
                      end
         default:     state_d = S_IDLE;
      endcase

      if (fail) begin
         retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
         retry_d   = retry_inc;
         state_d   = (retry_inc == 4'(MAX_RETRY)) ? S_FAULT : S_RST;
      end

      if (!link_en && (state_q != S_FAULT)) begin
         state_d = S_IDLE;
         retry_d = '0;
      end

      // Timer restarts on every state change and saturates otherwise
      if (state_d != state_q)                   timer_d = '0;
      else if (timer_q != TMR_W'(TMR_MAX))      timer_d = timer_q + TMR_W'(1);
   end

   assign gt_reset  = gt_reset_q;
   assign pixel_en  = pixel_en_q;
   assign link_up   = link_up_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state     = state_q;

endmodule

// File: tb/tb_gth_link_sequencer.sv
// Directed bench for gth_link_sequencer with a short timeout and retry limit.
module tb_gth_link_sequencer;

   localparam int unsigned ST_IDLE = 0, ST_RST = 1, ST_WPWR = 2, ST_WLOCK = 3,
                           ST_WDONE = 4, ST_RUN = 5, ST_FAULT = 6;

   logic       clk;
   logic       resetn;
   logic       link_en, fault_clr;
   logic [2:0] gtpowergood, txpmaresetdone, txprgdivresetdone;
   logic       tx_done, locked, underflow;
   logic       gt_reset, pixel_en, link_up, fault;
   logic [3:0] retry_cnt;
   logic [2:0] state;

   int n_chk = 0;
   int n_err = 0;

   gth_link_sequencer #(.RST_HOLD(16), .TIMEOUT(100), .MAX_RETRY(3)) dut (
      .clk(clk), .resetn(resetn), .link_en(link_en), .fault_clr(fault_clr),
      .gtpowergood(gtpowergood), .txpmaresetdone(txpmaresetdone),
      .txprgdivresetdone(txprgdivresetdone), .tx_done(tx_done), .locked(locked),
      .underflow(underflow), .gt_reset(gt_reset), .pixel_en(pixel_en),
      .link_up(link_up), .fault(fault), .retry_cnt(retry_cnt), .state(state)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input string tag, input int unsigned exp, input int max_cyc);
      int n = 0;
      while (32'(state) != exp && n < max_cyc) begin
         step(1);
         n++;
      end
      chk(tag, 32'(state), exp);
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, ".state"},    32'(state),     ST_IDLE);
      chk({tag, ".gt_reset"}, 32'(gt_reset),  1);
      chk({tag, ".pixel_en"}, 32'(pixel_en),  0);
      chk({tag, ".link_up"},  32'(link_up),   0);
      chk({tag, ".fault"},    32'(fault),     0);
      chk({tag, ".retry"},    32'(retry_cnt), 0);
   endtask

   initial begin
      int n;
      resetn = 1'b1; link_en = 1'b0; fault_clr = 1'b0;
      gtpowergood = '0; txpmaresetdone = '0; txprgdivresetdone = '0;
      tx_done = 1'b0; locked = 1'b0; underflow = 1'b0;
      #1 resetn = 1'b0;
      step(2);
      reset_outputs("reset");
      resetn = 1'b1;
      step(4);
      reset_outputs("post_reset_idle");

      // Normal bring-up
      link_en = 1'b1;
      step(1);
      chk("bringup.rst_entry", 32'(state), ST_RST);
      n = 0;
      while (32'(state) == ST_RST && n < 40) begin
         if (gt_reset !== 1'b1) chk("bringup.gt_reset_in_rst", 32'(gt_reset), 1);
         step(1);
         n++;
      end
      chk("bringup.rst_cycles", 32'(n), 16);
      chk("bringup.wait_pwr", 32'(state), ST_WPWR);
      chk("bringup.gt_reset_low", 32'(gt_reset), 0);
      gtpowergood = 3'b111; txpmaresetdone = 3'b111; txprgdivresetdone = 3'b111;
      tx_done = 1'b1; locked = 1'b1;
      wait_state("bringup.run", ST_RUN, 20);
      chk("bringup.link_up", 32'(link_up), 1);
      chk("bringup.pixel_en", 32'(pixel_en), 1);
      chk("bringup.retry", 32'(retry_cnt), 0);

      // 3-cycle underflow pulse in RUN
      underflow = 1'b1;
      step(1); chk("uf.run_e1", 32'(state), ST_RUN);
      step(1); chk("uf.run_e2", 32'(state), ST_RUN);
      step(1);
      underflow = 1'b0;
      chk("uf.left_run", 32'(state), ST_RST);
      chk("uf.retry", 32'(retry_cnt), 1);
      chk("uf.pixel_en", 32'(pixel_en), 0);
      chk("uf.link_up", 32'(link_up), 0);
      wait_state("uf.reseq_run", ST_RUN, 40);
      chk("uf.retry_in_run", 32'(retry_cnt), 1);
      step(99);
      chk("stable.retry_before", 32'(retry_cnt), 1);
      step(1);
      chk("stable.retry_cleared", 32'(retry_cnt), 0);

      // Shutdown during WAIT_DONE with two failures recorded
      tx_done = 1'b0;
      wait_state("shut.fail_run", ST_RST, 10);
      chk("shut.retry1", 32'(retry_cnt), 1);
      wait_state("shut.wdone1", ST_WDONE, 40);
      n = 0;
      while (32'(state) == ST_WDONE && n < 200) begin
         step(1);
         n++;
      end
      chk("shut.wdone_timeout_cycles", 32'(n), 100);
      chk("shut.timeout_rst", 32'(state), ST_RST);
      chk("shut.retry2", 32'(retry_cnt), 2);
      wait_state("shut.wdone2", ST_WDONE, 40);
      chk("shut.retry2_wdone", 32'(retry_cnt), 2);
      link_en = 1'b0;
      step(1);
      chk("shut.idle", 32'(state), ST_IDLE);
      chk("shut.retry_cleared", 32'(retry_cnt), 0);
      chk("shut.gt_reset", 32'(gt_reset), 1);

      // WAIT_LOCK timeouts exhaust retries
      tx_done = 1'b1; locked = 1'b0;
      step(3);
      link_en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wait_state($sformatf("to.wlock%0d", i), ST_WLOCK, 40);
         wait_state($sformatf("to.exit%0d", i), (i < 3) ? ST_RST : ST_FAULT, 120);
         chk($sformatf("to.retry%0d", i), 32'(retry_cnt), 32'(i));
      end
      chk("to.fault", 32'(fault), 1);
      chk("to.gt_reset", 32'(gt_reset), 1);
      chk("to.link_up", 32'(link_up), 0);
      chk("to.pixel_en", 32'(pixel_en), 0);

      // FAULT ignores link_en, releases on fault_clr
      link_en = 1'b0;
      step(3);
      chk("fault.hold_len0", 32'(state), ST_FAULT);
      chk("fault.retry_hold", 32'(retry_cnt), 3);
      link_en = 1'b1;
      step(2);
      chk("fault.hold_len1", 32'(state), ST_FAULT);
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      chk("fault.clr_idle", 32'(state), ST_IDLE);
      chk("fault.clr_retry", 32'(retry_cnt), 0);
      chk("fault.clr_fault", 32'(fault), 0);
      step(1);
      chk("fault.then_rst", 32'(state), ST_RST);

      // Asynchronous reset in the middle of RUN
      locked = 1'b1;
      wait_state("areset.run", ST_RUN, 60);
      chk("areset.link_up_before", 32'(link_up), 1);
      #2 resetn = 1'b0;
      #1;
      reset_outputs("areset");
      step(2);
      resetn = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
